// File: rtl/skinny_reg_bank.sv
// Byte-addressed register bank between the UART command bridge and the
// SKINNY-128-384 core: holds tweakey/plaintext, runs the core, captures ciphertext.
module skinny_reg_bank #(
  parameter logic [15:0] TIMEOUT = 16'd4096
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic [6:0]   addr,
  input  logic [7:0]   wdata,
  input  logic         write,
  input  logic         read_ack,
  output logic [7:0]   rdata,
  output logic [383:0] core_key,
  output logic [127:0] core_pt,
  output logic         core_start,
  input  logic         core_done,
  input  logic [127:0] core_ct,
  output logic         trigger
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t       r_state, w_state_nxt;
  logic [383:0] r_key;
  logic [127:0] r_pt;
  logic [127:0] r_ct;
  logic [7:0]   r_scratch;
  logic [15:0]  r_cyc;
  logic         r_start, r_done, r_timeout, r_err;

  logic w_run, w_wr_key, w_wr_pt, w_wr_ctrl, w_wr_scr;
  logic w_start_req, w_clear, w_err_set, w_stat_rd, w_expire;

  assign w_run       = (r_state == S_RUN);
  assign w_wr_key    = write && (addr < 7'h30);
  assign w_wr_pt     = write && (addr[6:4] == 3'h3);
  assign w_wr_ctrl   = write && (addr == 7'h50);
  assign w_wr_scr    = write && (addr == 7'h54);
  assign w_start_req = w_wr_ctrl && wdata[0] && !w_run;
  assign w_clear     = w_wr_ctrl && wdata[1];
  assign w_err_set   = w_run && (w_wr_key || w_wr_pt || (w_wr_ctrl && wdata[0]));
  assign w_stat_rd   = read_ack && (addr == 7'h51);
  // core_done outranks the timeout when both land on the same edge
  assign w_expire    = w_run && !core_done && (r_cyc == TIMEOUT);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_start_req) w_state_nxt = S_RUN;
      S_RUN:  if (core_done || w_expire) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_key     <= '0;
      r_pt      <= '0;
      r_ct      <= '0;
      r_scratch <= '0;
      r_cyc     <= '0;
      r_start   <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_start <= w_start_req;
      if (w_wr_key && !w_run) r_key[(47 - int'(addr[5:0]))*8 +: 8] <= wdata;
      if (w_wr_pt && !w_run)  r_pt[(15 - int'(addr[3:0]))*8 +: 8] <= wdata;
      if (w_wr_scr)           r_scratch <= wdata;
      if (w_run && core_done) r_ct <= core_ct;

      if (w_start_req)
        r_cyc <= '0;
      else if (w_run && !core_done && !w_expire && (r_cyc != 16'hFFFF))
        r_cyc <= r_cyc + 16'd1;

      if (w_run && core_done)          r_done <= 1'b1;
      else if (w_start_req)            r_done <= 1'b0;
      else if (w_clear && !w_run)      r_done <= 1'b0;

      if (w_expire)                    r_timeout <= 1'b1;
      else if (w_start_req)            r_timeout <= 1'b0;
      else if (w_clear && !w_run)      r_timeout <= 1'b0;

      if (w_err_set)                   r_err <= 1'b1;
      else if (w_clear || w_stat_rd)   r_err <= 1'b0;
    end
  end

  // Purely combinational so the bridge sees data in the cycle it samples
  always_comb begin
    rdata = '0;
    if (addr < 7'h30)
      rdata = r_key[(47 - int'(addr[5:0]))*8 +: 8];
    else if (addr[6:4] == 3'h3)
      rdata = r_pt[(15 - int'(addr[3:0]))*8 +: 8];
    else if (addr[6:4] == 3'h4)
      rdata = r_ct[(15 - int'(addr[3:0]))*8 +: 8];
    else begin
      case (addr)
        7'h51:   rdata = {4'b0000, r_err, r_timeout, r_done, w_run};
        7'h52:   rdata = r_cyc[7:0];
        7'h53:   rdata = r_cyc[15:8];
        7'h54:   rdata = r_scratch;
        default: rdata = '0;
      endcase
    end
  end

  assign core_key   = r_key;
  assign core_pt    = r_pt;
  assign core_start = r_start;
  assign trigger    = w_run;

endmodule

// File: tb/tb_skinny_reg_bank.sv
// Directed bench for skinny_reg_bank: instance A uses the default TIMEOUT,
// instance B uses TIMEOUT=16 for the abort path.
module tb_skinny_reg_bank;

  logic         clk = 1'b0;
  logic         n_reset = 1'b0;
  logic [6:0]   addr = '0;
  logic [7:0]   wdata = '0;
  logic         read_ack = 1'b0;
  logic         write_a = 1'b0, write_b = 1'b0;
  logic         done_a = 1'b0, done_b = 1'b0;
  logic [127:0] ct_a = '0, ct_b = '0;
  logic [7:0]   rdata_a, rdata_b;
  logic [383:0] key_a, key_b;
  logic [127:0] pt_a, pt_b;
  logic         start_a, start_b, trig_a, trig_b;

  int n_checks = 0;
  int n_errors = 0;
  int starts_a = 0;
  int s0;

  always #5 clk = ~clk;

  skinny_reg_bank dut_a (
    .clk(clk), .n_reset(n_reset), .addr(addr), .wdata(wdata), .write(write_a),
    .read_ack(read_ack), .rdata(rdata_a), .core_key(key_a), .core_pt(pt_a),
    .core_start(start_a), .core_done(done_a), .core_ct(ct_a), .trigger(trig_a)
  );

  skinny_reg_bank #(.TIMEOUT(16'd16)) dut_b (
    .clk(clk), .n_reset(n_reset), .addr(addr), .wdata(wdata), .write(write_b),
    .read_ack(read_ack), .rdata(rdata_b), .core_key(key_b), .core_pt(pt_b),
    .core_start(start_b), .core_done(done_b), .core_ct(ct_b), .trigger(trig_b)
  );

  always @(posedge clk) if (start_a) starts_a++;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // All bus tasks start and end on a falling edge, one cycle each.
  task automatic wr(input bit sel, input logic [6:0] a, input logic [7:0] d);
    addr = a; wdata = d;
    if (sel) write_b = 1'b1; else write_a = 1'b1;
    @(negedge clk);
    write_a = 1'b0; write_b = 1'b0;
  endtask

  task automatic rd(input bit sel, input logic [6:0] a, input logic [7:0] exp,
                    input string tag, input bit ack);
    addr = a; read_ack = ack;
    #1 check(tag, sel ? rdata_b : rdata_a, exp);
    @(negedge clk);
    read_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    #1;
    check("rst_start", start_a, 0);
    check("rst_trig", trig_a, 0);
    addr = 7'h51; #1 check("rst_status", rdata_a, 0);
    addr = 7'h00; #1 check("rst_key0", rdata_a, 0);
    @(negedge clk); @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);

    // key/pt write and readback
    for (int i = 0; i < 48; i++) wr(0, 7'(i), 8'(i));
    for (int i = 0; i < 16; i++) wr(0, 7'(48 + i), 8'(8'hA0 + i));
    for (int i = 0; i < 48; i++) rd(0, 7'(i), 8'(i), "key_rd", 0);
    for (int i = 0; i < 16; i++) rd(0, 7'(48 + i), 8'(8'hA0 + i), "pt_rd", 0);
    check("core_key_hi", key_a[383:376], 8'h00);
    check("core_key_lo", key_a[7:0], 8'h2F);
    check("core_pt_hi", pt_a[127:120], 8'hA0);
    rd(0, 7'h50, 8'h00, "ctrl_rd", 0);
    wr(0, 7'h54, 8'h5A);
    rd(0, 7'h54, 8'h5A, "scratch_rd", 0);

    // normal run, core answers 40 cycles after start
    s0 = starts_a;
    wr(0, 7'h50, 8'h01);
    check("start_pulse", start_a, 1);
    check("trig_run", trig_a, 1);
    rd(0, 7'h51, 8'h01, "status_busy", 0);
    check("start_one_cycle", start_a, 0);
    repeat (39) @(negedge clk);
    done_a = 1'b1; ct_a = 128'h00112233445566778899AABBCCDDEEFF;
    @(negedge clk);
    done_a = 1'b0;
    check("trig_idle", trig_a, 0);
    check("one_start", starts_a - s0, 1);
    rd(0, 7'h40, 8'h00, "ct_first", 0);
    rd(0, 7'h4F, 8'hFF, "ct_last", 0);
    rd(0, 7'h47, 8'h77, "ct_mid", 0);
    rd(0, 7'h51, 8'h02, "status_done", 0);
    rd(0, 7'h52, 8'h28, "cyc_lo", 0);
    rd(0, 7'h53, 8'h00, "cyc_hi", 0);

    // protection while running; status read clears err
    s0 = starts_a;
    wr(0, 7'h50, 8'h01);
    wr(0, 7'h05, 8'h77);
    wr(0, 7'h50, 8'h01);
    rd(0, 7'h51, 8'h09, "status_err", 1);
    wr(0, 7'h54, 8'h3C);
    done_a = 1'b1; ct_a = 128'h0;
    @(negedge clk);
    done_a = 1'b0;
    rd(0, 7'h51, 8'h02, "status_err_clr", 0);
    rd(0, 7'h05, 8'h05, "key_protect", 0);
    check("core_key_prot", key_a[343:336], 8'h05);
    check("one_start_run", starts_a - s0, 1);
    rd(0, 7'h54, 8'h3C, "scratch_run", 0);
    rd(0, 7'h52, 8'h04, "cyc_short", 0);

    // done and clear on the same edge: set wins
    wr(0, 7'h50, 8'h01);
    @(negedge clk); @(negedge clk);
    addr = 7'h50; wdata = 8'h02; write_a = 1'b1;
    done_a = 1'b1; ct_a = 128'hC3000000000000000000000000000000;
    @(negedge clk);
    write_a = 1'b0; done_a = 1'b0;
    rd(0, 7'h51, 8'h02, "set_beats_clr", 0);
    rd(0, 7'h52, 8'h02, "cyc_same", 0);
    rd(0, 7'h40, 8'hC3, "ct_same", 0);
    wr(0, 7'h50, 8'h02);
    rd(0, 7'h51, 8'h00, "status_clr", 0);

    // timeout on instance B
    wr(1, 7'h50, 8'h01);
    check("b_start", start_b, 1);
    repeat (16) @(negedge clk);
    check("b_trig_last", trig_b, 1);
    @(negedge clk);
    check("b_trig_off", trig_b, 0);
    rd(1, 7'h51, 8'h04, "b_status_to", 0);
    rd(1, 7'h52, 8'h10, "b_cyc_lo", 0);
    rd(1, 7'h53, 8'h00, "b_cyc_hi", 0);
    done_b = 1'b1; ct_b = '1;
    @(negedge clk);
    done_b = 1'b0;
    rd(1, 7'h51, 8'h04, "b_late_done", 0);
    rd(1, 7'h4F, 8'h00, "b_ct_kept", 0);

    // unmapped addresses
    wr(0, 7'h60, 8'h55);
    wr(0, 7'h7F, 8'hAA);
    rd(0, 7'h60, 8'h00, "unmap_60", 0);
    rd(0, 7'h7F, 8'h00, "unmap_7f", 0);
    rd(0, 7'h54, 8'h3C, "unmap_no_side", 0);

    // reset mid-run
    wr(0, 7'h50, 8'h01);
    @(negedge clk);
    n_reset = 1'b0;
    #1;
    check("rst_run_trig", trig_a, 0);
    check("rst_run_start", start_a, 0);
    check("rst_run_key", {127'b0, |key_a}, 0);
    check("rst_run_pt", {127'b0, |pt_a}, 0);
    for (int i = 0; i < 128; i++) begin
      addr = 7'(i);
      #1 check("rst_all_rd", rdata_a, 0);
    end
    @(negedge clk);
    n_reset = 1'b1;
    done_a = 1'b1; ct_a = '1;
    @(negedge clk);
    done_a = 1'b0;
    rd(0, 7'h51, 8'h00, "post_rst_status", 0);
    rd(0, 7'h40, 8'h00, "post_rst_ct", 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
